// File: rtl/mul_rr_sched.sv
// mul_rr_sched: round-robin scheduler/sequencer sharing one repeated-addition
// multiplier datapath (registers A, B, P) among NREQ requesters.
//
// Optional feature macro: MUL_SWAP_EN -- when defined, the larger operand is
// loaded into A so the loop runs min(a,b) times.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req   [NREQ]      per-requester request level
//   op_a, op_b        packed operands, slice i = op_x[i*WIDTH +: WIDTH]
//   gnt   [NREQ]      one-hot grant, held for the whole transaction
//   done  [NREQ]      one-cycle completion pulse to the granted requester
//   result[WIDTH]     product, updated in the done cycle and held afterwards
//   busy              state is not IDLE
//   dp_data[WIDTH]    datapath input bus
//   lda/ldb/ldp/clrp/decb  datapath strobes
//   dp_eqz            datapath B == 0
//   dp_prod[WIDTH]    datapath P register
module mul_rr_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result,
    output logic                    busy,
    output logic [WIDTH-1:0]        dp_data,
    output logic                    lda,
    output logic                    ldb,
    output logic                    ldp,
    output logic                    clrp,
    output logic                    decb,
    input  logic                    dp_eqz,
    input  logic [WIDTH-1:0]        dp_prod
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    gidx_q;
    logic [IW-1:0]    win_idx;
    logic             win_vld;
    logic [CW-1:0]    cand;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [WIDTH-1:0] opnd_first;
    logic [WIDTH-1:0] opnd_second;

    // Unpack the operand buses into per-requester slices
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = op_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = op_b[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first set req bit starting at ptr+1, wrapping
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!win_vld && req[cand[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IW-1:0];
            end
        end
    end

`ifdef MUL_SWAP_EN
    logic swap_q;

    // Larger operand goes to A so the loop count is the smaller one
    assign opnd_first  = swap_q ? b_arr[gidx_q] : a_arr[gidx_q];
    assign opnd_second = swap_q ? a_arr[gidx_q] : b_arr[gidx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_q <= 1'b0;
        end else if (state == ST_IDLE && win_vld) begin
            swap_q <= (b_arr[win_idx] > a_arr[win_idx]);
        end
    end
`else
    assign opnd_first  = a_arr[gidx_q];
    assign opnd_second = b_arr[gidx_q];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded datapath controls
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        lda       = 1'b0;
        ldb       = 1'b0;
        ldp       = 1'b0;
        clrp      = 1'b0;
        decb      = 1'b0;
        dp_data   = '0;
        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    state_nxt = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                lda       = 1'b1;
                dp_data   = opnd_first;
                state_nxt = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                ldb       = 1'b1;
                clrp      = 1'b1;
                dp_data   = opnd_second;
                state_nxt = ST_MUL;
            end
            ST_MUL: begin
                // eqz is sampled from the registered B, so the last add
                // has already landed in P when it goes high
                if (!dp_eqz) begin
                    ldp  = 1'b1;
                    decb = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant, pointer, result and done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            gidx_q <= '0;
            ptr_q  <= IW'(NREQ - 1);
            result <= '0;
            done   <= '0;
        end else begin
            done <= '0;
            if (state == ST_IDLE && win_vld) begin
                gnt    <= NREQ'(1) << win_idx;
                gidx_q <= win_idx;
            end
            if (state == ST_MUL && dp_eqz) begin
                result <= dp_prod;
                done   <= gnt;
            end
            if (state == ST_DONE) begin
                gnt   <= '0;
                ptr_q <= gidx_q;
            end
        end
    end

endmodule
